// File: rtl/tmc_mult_pkg.sv
// rtl/tmc_mult_pkg.sv - op encodings, slice-count helper and operand signedness decode
package tmc_mult_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXSS = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXUU = 2'b11
    } op_e;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_SLICE_W = 16;
    localparam int DEF_TAG_W   = 5;

    function automatic int num_slices(input int data_w, input int slice_w);
        return data_w / slice_w;
    endfunction

    // {a_signed, b_signed}
    function automatic logic [1:0] sel_signed(input op_e op);
        case (op)
            OP_MULXSS: return 2'b11;
            OP_MULXSU: return 2'b10;
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/tmc_mult_slice.sv
// rtl/tmc_mult_slice.sv - registered unsigned slice multiply with enable
module tmc_mult_slice #(
    parameter int SLICE_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [SLICE_W-1:0]     a,
    input  logic [SLICE_W-1:0]     b,
    output logic [2*SLICE_W-1:0]   p
);

    logic [2*SLICE_W-1:0] p_q;
    logic [2*SLICE_W-1:0] p_d;

    always_comb begin
        p_d = p_q;
        if (en) begin
            p_d = {{SLICE_W{1'b0}}, a} * {{SLICE_W{1'b0}}, b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/tmc_mult_pipe.sv
// rtl/tmc_mult_pipe.sv - pipelined sliced multiplier; TMC_MULT_OUT_REG_EN adds a registered output stage
module tmc_mult_pipe
    import tmc_mult_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SLICE_W = DEF_SLICE_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int N  = num_slices(DATA_W, SLICE_W);
    localparam int PW = 2 * DATA_W;

    logic adv;
    logic [2*SLICE_W-1:0] prod [N*N];

    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    op_e               op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic              v1_q, v1_d;

    logic [PW-1:0]     full_sum;
    logic [DATA_W-1:0] res2_q, res2_d;
    logic [TAG_W-1:0]  tag2_q, tag2_d;
    logic              v2_q, v2_d;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            tmc_mult_slice #(.SLICE_W(SLICE_W)) u_slice (
                .clk   (clk),
                .reset (reset),
                .en    (adv),
                .a     (in_a[i*SLICE_W +: SLICE_W]),
                .b     (in_b[j*SLICE_W +: SLICE_W]),
                .p     (prod[i*N+j])
            );
        end
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        tag_d    = tag_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        v1_d     = v1_q;
        if (adv) begin
            a_d      = in_a;
            b_d      = in_b;
            op_d     = op_e'(in_op);
            tag_d    = in_tag;
            sign_a_d = in_a[DATA_W-1] & sel_signed(op_e'(in_op))[1];
            sign_b_d = in_b[DATA_W-1] & sel_signed(op_e'(in_op))[0];
            v1_d     = in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_MUL;
            tag_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            v1_q     <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            v1_q     <= v1_d;
        end
    end

    // Unsigned sum of slices, then subtract the two's-complement weight of each signed MSB.
    always_comb begin
        full_sum = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                full_sum = full_sum + (PW'(prod[i*N+j]) << ((i + j) * SLICE_W));
            end
        end
        if (sign_a_q) begin
            full_sum = full_sum - {b_q, {DATA_W{1'b0}}};
        end
        if (sign_b_q) begin
            full_sum = full_sum - {a_q, {DATA_W{1'b0}}};
        end
    end

    always_comb begin
        res2_d = res2_q;
        tag2_d = tag2_q;
        v2_d   = v2_q;
        if (adv) begin
            res2_d = (op_q == OP_MUL) ? full_sum[DATA_W-1:0] : full_sum[PW-1:DATA_W];
            tag2_d = tag_q;
            v2_d   = v1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res2_q <= '0;
            tag2_q <= '0;
            v2_q   <= 1'b0;
        end else begin
            res2_q <= res2_d;
            tag2_q <= tag2_d;
            v2_q   <= v2_d;
        end
    end

`ifdef TMC_MULT_OUT_REG_EN
    logic [DATA_W-1:0] res3_q, res3_d;
    logic [TAG_W-1:0]  tag3_q, tag3_d;
    logic              v3_q, v3_d;

    always_comb begin
        res3_d = res3_q;
        tag3_d = tag3_q;
        v3_d   = v3_q;
        if (adv) begin
            res3_d = res2_q;
            tag3_d = tag2_q;
            v3_d   = v2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res3_q <= '0;
            tag3_q <= '0;
            v3_q   <= 1'b0;
        end else begin
            res3_q <= res3_d;
            tag3_q <= tag3_d;
            v3_q   <= v3_d;
        end
    end

    assign out_valid  = v3_q;
    assign out_result = res3_q;
    assign out_tag    = tag3_q;
`else
    assign out_valid  = v2_q;
    assign out_result = res2_q;
    assign out_tag    = tag2_q;
`endif

endmodule

// File: tb/tb_tmc_mult_pipe.sv
// tb/tb_tmc_mult_pipe.sv - scoreboard bench for tmc_mult_pipe, honours TMC_MULT_OUT_REG_EN
module tb_tmc_mult_pipe;

`ifdef TMC_MULT_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          acc;
        bit          chk_lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [1:0]  in_op;
    logic [4:0]  in_tag, out_tag;

    logic        in_valid64, in_ready64, out_valid64, out_ready64;
    logic [63:0] in_a64, in_b64, out_result64;
    logic [1:0]  in_op64;
    logic [4:0]  in_tag64, out_tag64;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    exp_t sb[$];
    logic [63:0] sb64[$];

    bit  tog_en = 1'b0;
    int  pidx   = 0;
    bit  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    bit          prev_stall = 1'b0;
    logic [31:0] prev_res;
    logic [4:0]  prev_tag;
    bit          seen_after_reset;

    tmc_mult_pipe u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    tmc_mult_pipe #(.DATA_W(64), .SLICE_W(16), .TAG_W(5)) u_dut64 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid64),
        .in_ready   (in_ready64),
        .in_a       (in_a64),
        .in_b       (in_b64),
        .in_op      (in_op64),
        .in_tag     (in_tag64),
        .out_valid  (out_valid64),
        .out_ready  (out_ready64),
        .out_result (out_result64),
        .out_tag    (out_tag64)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) begin
                out_ready = pat[pidx];
                pidx = (pidx + 1) % 4;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // 32-bit monitor: pops on every output transfer and checks stall stability.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_result", {32'd0, out_result}, {32'd0, prev_res});
                chk("stall_tag", {59'd0, out_tag}, {59'd0, prev_tag});
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual_tag=%0d result=0x%0h required=none", out_tag, out_result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", {32'd0, out_result}, {32'd0, e.res});
                    chk("tag", {59'd0, out_tag}, {59'd0, e.tag});
                    if (e.chk_lat) chk("latency", 64'(cyc - e.acc), 64'(LAT));
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_res   <= out_result;
            prev_tag   <= out_tag;
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid64 && out_ready64) begin
            if (sb64.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output64 actual=0x%0h required=none", out_result64);
            end else begin
                chk("result64", out_result64, sb64.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [4:0] tag, input logic [31:0] res, input bit chk_lat, input bit push);
        int   n;
        exp_t e;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_tag   = tag;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout tag=%0d in_ready=0 required=1", tag);
        end else if (push) begin
            e.res = res;
            e.tag = tag;
            e.acc = cyc;
            e.chk_lat = chk_lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || sb64.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sb.size() + sb64.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
        out_ready = 1'b1;
        in_valid64 = 1'b0; in_a64 = '0; in_b64 = '0; in_op64 = '0; in_tag64 = '0;
        out_ready64 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_result", {32'd0, out_result}, 64'd0);
        chk("reset_out_tag", {59'd0, out_tag}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        send(32'h0001_0003, 32'h0002_0005, 2'b00, 5'd17, 32'h000B_000F, 1'b1, 1'b1);
        send(32'hFFFF_FFFF, 32'h0000_0002, 2'b01, 5'd18, 32'hFFFF_FFFF, 1'b1, 1'b1);
        send(32'hFFFF_FFFF, 32'h0000_0002, 2'b11, 5'd19, 32'h0000_0001, 1'b1, 1'b1);
        send(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 5'd20, 32'h8000_0000, 1'b1, 1'b1);
        send(32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 5'd21, 32'h7FFF_FFFF, 1'b1, 1'b1);
        drain();

        // (2^16+i)*(2^16+1) mod 2^32 = ((i+1)<<16) + i
        for (int i = 0; i < 8; i++) begin
            send(32'h0001_0000 + 32'(i), 32'h0001_0001, 2'b00, 5'(i),
                 (32'(i + 1) << 16) | 32'(i), 1'b1, 1'b1);
        end
        drain();

        tog_en = 1'b1;
        pidx = 0;
        for (int i = 0; i < 8; i++) begin
            send(32'(i + 1), 32'd3, 2'b00, 5'(i), 32'(3 * (i + 1)), 1'b0, 1'b1);
        end
        tog_en = 1'b0;
        out_ready = 1'b1;
        drain();

        in_valid64 = 1'b1;
        in_a64 = 64'hFFFF_FFFF_FFFF_FFFF;
        in_b64 = 64'hFFFF_FFFF_FFFF_FFFF;
        in_op64 = 2'b11;
        in_tag64 = 5'd9;
        @(negedge clk);
        chk("in_ready64", {63'd0, in_ready64}, 64'd1);
        sb64.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        @(posedge clk);
        #1;
        in_valid64 = 1'b0;
        drain();

        send(32'd5, 32'd7, 2'b00, 5'd1, 32'd35, 1'b0, 1'b0);
        send(32'd6, 32'd7, 2'b00, 5'd2, 32'd42, 1'b0, 1'b0);
        out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_flush_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        seen_after_reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen_after_reset = 1'b1;
        end
        chk("no_output_after_reset", {63'd0, seen_after_reset}, 64'd0);
        chk("in_ready_post_flush", {63'd0, in_ready}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
